// File: rtl/inst_fetch_queue.sv
// Fetch front-end: issues req/ack instruction fetches and buffers {pc, inst} pairs for decode.
// Define FETCHQ_BYPASS_EN to forward an ack straight to the head outputs when the queue is empty.
module inst_fetch_queue #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic                     clk,
  input  logic                     rst,
  output logic                     imem_req,
  output logic [31:0]              imem_addr,
  input  logic                     imem_ack,
  input  logic [31:0]              imem_rdata,
  input  logic                     redirect_en,
  input  logic [31:0]              redirect_pc,
  input  logic                     id_ready,
  output logic                     inst_valid,
  output logic [31:0]              inst_out,
  output logic [31:0]              pc_out,
  output logic [$clog2(DEPTH):0]   fq_count
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;
  localparam logic [CntW-1:0] DepthC = CntW'(DEPTH);

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StWait  = 2'd1;
  localparam logic [1:0] StDrain = 2'd2;

  logic [1:0]      state_q, state_d;
  logic [31:0]     fetch_pc_q, fetch_pc_d;
  logic            req_q, req_d;
  logic [31:0]     addr_q, addr_d;
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0] count_q, count_d;
  logic [31:0]     pc_mem_q [DEPTH];
  logic [31:0]     pc_mem_d [DEPTH];
  logic [31:0]     inst_mem_q [DEPTH];
  logic [31:0]     inst_mem_d [DEPTH];

  logic ack_w, head_valid, deq, enq, byp_take;

  assign ack_w      = req_q & imem_ack;
  assign head_valid = (count_q != '0);
  assign deq        = head_valid & id_ready & ~redirect_en;

`ifdef FETCHQ_BYPASS_EN
  logic byp_valid;
  assign byp_valid = ~head_valid & (state_q == StWait) & ack_w & ~redirect_en;
  assign byp_take  = byp_valid & id_ready;
`else
  assign byp_take  = 1'b0;
`endif

  // A bypassed response that decode takes in the ack cycle never occupies a slot.
  assign enq = (state_q == StWait) & ack_w & ~redirect_en & ~byp_take;

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    req_d      = req_q;
    addr_d     = addr_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    pc_mem_d   = pc_mem_q;
    inst_mem_d = inst_mem_q;

    unique case (state_q)
      StIdle: begin
        if (!redirect_en && (count_q < DepthC)) begin
          req_d   = 1'b1;
          addr_d  = fetch_pc_q;
          state_d = StWait;
        end
      end
      StWait: begin
        if (ack_w) begin
          req_d      = 1'b0;
          state_d    = StIdle;
          fetch_pc_d = fetch_pc_q + 32'd4;
        end else if (redirect_en) begin
          state_d = StDrain;
        end
      end
      StDrain: begin
        if (ack_w) begin
          req_d   = 1'b0;
          state_d = StIdle;
        end
      end
      default: begin
        req_d   = 1'b0;
        state_d = StIdle;
      end
    endcase

    if (redirect_en) begin
      fetch_pc_d = {redirect_pc[31:2], 2'b00};
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      count_d    = '0;
    end else begin
      if (enq) begin
        pc_mem_d[wr_ptr_q]   = fetch_pc_q;
        inst_mem_d[wr_ptr_q] = imem_rdata;
        wr_ptr_d             = wr_ptr_q + 1'b1;
      end
      if (deq) begin
        rd_ptr_d = rd_ptr_q + 1'b1;
      end
      if (enq && !deq) begin
        count_d = count_q + 1'b1;
      end else if (!enq && deq) begin
        count_d = count_q - 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      fetch_pc_q <= RESET_PC;
      req_q      <= 1'b0;
      addr_q     <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      req_q      <= req_d;
      addr_q     <= addr_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
    end
  end

  // Storage needs no reset: the head is masked while count is zero.
  always_ff @(posedge clk) begin
    pc_mem_q   <= pc_mem_d;
    inst_mem_q <= inst_mem_d;
  end

  always_comb begin
    inst_valid = head_valid;
    inst_out   = head_valid ? inst_mem_q[rd_ptr_q] : NOP_INST;
    pc_out     = head_valid ? pc_mem_q[rd_ptr_q] : 32'h0;
`ifdef FETCHQ_BYPASS_EN
    if (byp_valid) begin
      inst_valid = 1'b1;
      inst_out   = imem_rdata;
      pc_out     = fetch_pc_q;
    end
`endif
  end

  assign imem_req  = req_q;
  assign imem_addr = addr_q;
  assign fq_count  = count_q;

endmodule

// File: tb/tb_inst_fetch_queue.sv
// Scoreboard bench for inst_fetch_queue: request addresses and dequeued {pc, inst} pairs are
// checked against hand-computed expectation queues by a negedge monitor.
module tb_inst_fetch_queue;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        redirect_en;
  logic [31:0] redirect_pc;
  logic        id_ready;
  logic        inst_valid;
  logic [31:0] inst_out;
  logic [31:0] pc_out;
  logic [2:0]  fq_count;

  always #5 clk = ~clk;

  inst_fetch_queue #(
    .DEPTH    (4),
    .RESET_PC (32'h0000_0000),
    .NOP_INST (32'h0000_0013)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .redirect_en (redirect_en),
    .redirect_pc (redirect_pc),
    .id_ready    (id_ready),
    .inst_valid  (inst_valid),
    .inst_out    (inst_out),
    .pc_out      (pc_out),
    .fq_count    (fq_count)
  );

  // Memory model: word = ~addr except a fixed word at 0x20; slow_addr takes 3 extra cycles.
  logic [7:0]  age;
  logic [31:0] slow_addr;
  assign imem_ack   = imem_req && (age >= ((imem_addr == slow_addr) ? 8'd3 : 8'd0));
  assign imem_rdata = (imem_addr == 32'h20) ? 32'h00A0_0093 : ~imem_addr;

  always @(posedge clk) begin
    if (rst) age <= 8'd0;
    else     age <= (imem_req && !imem_ack) ? age + 8'd1 : 8'd0;
  end

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;
  logic [31:0] exp_req[$];
  logic [63:0] exp_deq[$];
  logic        mon_on = 1'b0;
  logic        prev_req = 1'b0;
  logic [31:0] prev_addr = 32'h0;
  logic [2:0]  max_cnt = 3'd0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic fail_now(input string name, input logic [31:0] act);
    n_checks++;
    $display("FAIL %s: got %h expected none", name, act);
  endtask

  // Monitor: pops expectations whenever the DUT presents a new request or a dequeue.
  always @(negedge clk) begin
    logic [63:0] e;
    if (mon_on && !rst) begin
      if (imem_req && !prev_req) begin
        if (exp_req.size() == 0) fail_now("unexpected_req", imem_addr);
        else chk("req_addr", imem_addr, exp_req.pop_front());
      end else if (imem_req && prev_req) begin
        chk("req_addr_hold", imem_addr, prev_addr);
      end
      if (inst_valid && id_ready && !redirect_en) begin
        if (exp_deq.size() == 0) begin
          fail_now("unexpected_deq", pc_out);
        end else begin
          e = exp_deq.pop_front();
          chk("deq_pc", pc_out, e[63:32]);
          chk("deq_inst", inst_out, e[31:0]);
        end
      end
      if (fq_count > max_cnt) max_cnt = fq_count;
    end
    prev_req  = imem_req;
    prev_addr = imem_addr;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input logic redir, input logic [31:0] rpc, input logic rdy);
    rst = 1'b1; redirect_en = 1'b0; redirect_pc = 32'h0; id_ready = 1'b0;
    mon_on = 1'b0; max_cnt = 3'd0;
    step();
    step();
    chk("rst_req", {31'h0, imem_req}, 32'h0);
    chk("rst_valid", {31'h0, inst_valid}, 32'h0);
    chk("rst_inst", inst_out, 32'h0000_0013);
    chk("rst_pc", pc_out, 32'h0);
    chk("rst_count", {29'h0, fq_count}, 32'h0);
    rst = 1'b0; redirect_en = redir; redirect_pc = rpc; id_ready = rdy;
    mon_on = 1'b1;
  endtask

  task automatic wait_drain(input string name, input int budget);
    for (int i = 0; i < budget; i++) begin
      if (exp_req.size() == 0 && exp_deq.size() == 0) return;
      step();
    end
    n_checks++;
    $display("FAIL %s_timeout: got %0d/%0d pending expected 0/0", name, exp_req.size(),
             exp_deq.size());
    exp_req.delete();
    exp_deq.delete();
  endtask

  task automatic wait_req(input string name, input logic [31:0] addr);
    for (int i = 0; i < 50; i++) begin
      if (imem_req && imem_addr == addr) return;
      step();
    end
    fail_now({name, "_req_timeout"}, addr);
  endtask

  initial begin
    slow_addr = 32'hFFFF_FFFF;

    // Zero-wait memory, decode always ready.
    exp_req = '{32'h0, 32'h4, 32'h8};
    exp_deq = '{{32'h0, 32'hFFFF_FFFF}, {32'h4, 32'hFFFF_FFFB}, {32'h8, 32'hFFFF_FFF7}};
    do_reset(1'b0, 32'h0, 1'b1);
    wait_drain("stream", 40);
    mon_on = 1'b0;
    chk("stream_max_count_le1", {31'h0, max_cnt <= 3'd1}, 32'h1);

    // Decode stalled: fill to DEPTH, issue stops, one pop frees a slot.
    exp_req = '{32'h0, 32'h4, 32'h8, 32'hC};
    do_reset(1'b0, 32'h0, 1'b0);
    wait_drain("fill", 40);
    repeat (8) step();
    chk("full_count", {29'h0, fq_count}, 32'h4);
    chk("full_no_req", {31'h0, imem_req}, 32'h0);
    chk("full_head_valid", {31'h0, inst_valid}, 32'h1);
    chk("full_head_pc", pc_out, 32'h0);
    chk("full_head_inst", inst_out, 32'hFFFF_FFFF);
    exp_req.push_back(32'h10);
    exp_deq.push_back({32'h0, 32'hFFFF_FFFF});
    id_ready = 1'b1;
    step();
    id_ready = 1'b0;
    wait_drain("refill", 40);
    repeat (4) step();
    chk("refill_count", {29'h0, fq_count}, 32'h4);
    chk("refill_head_pc", pc_out, 32'h4);
    chk("refill_head_inst", inst_out, 32'hFFFF_FFFB);
    mon_on = 1'b0;

    // Redirect while a slow request is outstanding: drain it, flush, restart at 0x100.
    slow_addr = 32'h8;
    exp_req = '{32'h0, 32'h4, 32'h8, 32'h100};
    exp_deq = '{{32'h100, 32'hFFFF_FEFF}};
    do_reset(1'b0, 32'h0, 1'b0);
    wait_req("drain", 32'h8);
    step();
    redirect_en = 1'b1; redirect_pc = 32'h103; id_ready = 1'b1;
    step();
    redirect_en = 1'b0;
    chk("drain_flush_count", {29'h0, fq_count}, 32'h0);
    chk("drain_req_held", {31'h0, imem_req}, 32'h1);
    chk("drain_addr_held", imem_addr, 32'h8);
    wait_drain("drain", 40);
    mon_on = 1'b0;
    slow_addr = 32'hFFFF_FFFF;

    // Redirect coinciding with the ack for 0x4; the pop offered in that cycle is ignored.
    exp_req = '{32'h0, 32'h4, 32'h40};
    exp_deq = '{{32'h40, 32'hFFFF_FFBF}};
    do_reset(1'b0, 32'h0, 1'b0);
    wait_req("ackredir", 32'h4);
    redirect_en = 1'b1; redirect_pc = 32'h40; id_ready = 1'b1;
    step();
    redirect_en = 1'b0;
    chk("ackredir_count", {29'h0, fq_count}, 32'h0);
    wait_drain("ackredir", 40);
    mon_on = 1'b0;

    // Redirect from IDLE to the last word; fetch_pc wraps to 0.
    exp_req = '{32'hFFFF_FFFC, 32'h0};
    exp_deq = '{{32'hFFFF_FFFC, 32'h0000_0003}, {32'h0, 32'hFFFF_FFFF}};
    do_reset(1'b1, 32'hFFFF_FFFC, 1'b1);
    step();
    redirect_en = 1'b0;
    wait_drain("wrap", 40);
    mon_on = 1'b0;

    // Empty queue, ack at 0x20 with decode ready.
    exp_req = '{32'h20};
    exp_deq = '{{32'h20, 32'h00A0_0093}};
    do_reset(1'b1, 32'h20, 1'b1);
    step();
    redirect_en = 1'b0;
    wait_req("ack20", 32'h20);
`ifdef FETCHQ_BYPASS_EN
    chk("byp_valid", {31'h0, inst_valid}, 32'h1);
    chk("byp_inst", inst_out, 32'h00A0_0093);
    chk("byp_pc", pc_out, 32'h20);
    step();
    chk("byp_count", {29'h0, fq_count}, 32'h0);
`else
    chk("nobyp_valid", {31'h0, inst_valid}, 32'h0);
    chk("nobyp_inst", inst_out, 32'h0000_0013);
    step();
    chk("nobyp_count", {29'h0, fq_count}, 32'h1);
`endif
    wait_drain("ack20", 40);
    mon_on = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
